// File: rtl/mac_pkg.sv
// Shared types and constants for the Ethernet receive controller.
// Holds the FSM state encoding, header geometry and default addresses.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HDR    = 2'd1,
        STREAM = 2'd2
    } state_t;

    localparam int          ETH_HDR_LEN   = 14;
    localparam int          PKTBUF_AW     = 11;
    localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] DEF_MY_MAC    = 48'h02_00_00_00_00_01;
    localparam logic [15:0] DEF_ETHERTYPE = 16'h88B5;

    // Byte idx of a MAC address as it appears on the wire (MSB first).
    function automatic logic [7:0] mac_byte(input logic [47:0] mac,
                                            input logic [2:0]  idx);
        int i;
        i = int'(idx);
        return mac[47 - 8*i -: 8];
    endfunction

endpackage

// File: rtl/sat_ctr.sv
// Saturating up-counter with synchronous active-high reset.
module sat_ctr #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_inc && (r_q != '1)) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/mac_rx_ctrl.sv
// Receive controller: filters a buffered frame on DA/EtherType and
// streams its payload bytes out over a valid/ready handshake.
module mac_rx_ctrl
    import mac_pkg::*;
#(
    parameter logic [47:0] MY_MAC    = DEF_MY_MAC,
    parameter logic [15:0] ETHERTYPE = DEF_ETHERTYPE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        doorbell,
    input  logic [10:0] pktbuf_maxaddr,
    output logic [10:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic [15:0] cnt_ok,
    output logic [15:0] cnt_drop,
    output logic [15:0] cnt_overrun
);

    state_t      r_state;
    state_t      w_next;
    logic [10:0] r_rd_addr;
    logic [10:0] r_maxaddr;
    logic        r_uc_ok;
    logic        r_bc_ok;
    logic        r_et_ok;

    logic w_runt;
    logic w_accept;
    logic w_in_da;
    logic w_uc_ok;
    logic w_bc_ok;
    logic w_et_ok;
    logic w_hdr_end;
    logic w_hdr_ok;
    logic w_xfer;
    logic w_last;
    logic w_inc_ok;
    logic w_inc_drop;
    logic w_inc_ovr;

    assign w_runt   = pktbuf_maxaddr < 11'(ETH_HDR_LEN);
    assign w_accept = (r_state == IDLE) && doorbell && !w_runt;
    assign w_in_da  = r_rd_addr < 11'd6;

    // Flags fold in the current byte so the decision at byte 13 is complete.
    assign w_uc_ok = r_uc_ok &
        (!w_in_da || (rd_data == mac_byte(MY_MAC, r_rd_addr[2:0])));
    assign w_bc_ok = r_bc_ok &
        (!w_in_da || (rd_data == mac_byte(BCAST_MAC, r_rd_addr[2:0])));
    assign w_et_ok = r_et_ok &
        !((r_rd_addr == 11'd12) && (rd_data != ETHERTYPE[15:8])) &
        !((r_rd_addr == 11'd13) && (rd_data != ETHERTYPE[7:0]));

    assign w_hdr_end = (r_state == HDR) &&
                       (r_rd_addr == 11'(ETH_HDR_LEN - 1));
    assign w_hdr_ok  = (w_uc_ok || w_bc_ok) && w_et_ok;
    assign w_last    = r_rd_addr == r_maxaddr;
    assign w_xfer    = (r_state == STREAM) && out_ready;

    assign w_inc_ok   = w_xfer && w_last;
    assign w_inc_drop = ((r_state == IDLE) && doorbell && w_runt) ||
                        (w_hdr_end && !w_hdr_ok);
    assign w_inc_ovr  = (r_state != IDLE) && doorbell;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) w_next = HDR;
            end
            HDR: begin
                if (w_hdr_end) w_next = w_hdr_ok ? STREAM : IDLE;
            end
            STREAM: begin
                if (w_xfer && w_last) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        busy      = 1'b0;
        unique case (r_state)
            IDLE: begin
                busy = 1'b0;
            end
            HDR: begin
                busy = 1'b1;
            end
            STREAM: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = rd_data;
                out_last  = w_last;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_addr <= '0;
            r_maxaddr <= '0;
            r_uc_ok   <= 1'b0;
            r_bc_ok   <= 1'b0;
            r_et_ok   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_rd_addr <= '0;
                    if (w_accept) begin
                        r_maxaddr <= pktbuf_maxaddr;
                        r_uc_ok   <= 1'b1;
                        r_bc_ok   <= 1'b1;
                        r_et_ok   <= 1'b1;
                    end
                end
                HDR: begin
                    r_uc_ok <= w_uc_ok;
                    r_bc_ok <= w_bc_ok;
                    r_et_ok <= w_et_ok;
                    if (w_hdr_end && !w_hdr_ok) begin
                        r_rd_addr <= '0;
                    end else begin
                        r_rd_addr <= r_rd_addr + 11'd1;
                    end
                end
                STREAM: begin
                    if (w_xfer) begin
                        r_rd_addr <= w_last ? 11'd0 : r_rd_addr + 11'd1;
                    end
                end
                default: begin
                    r_rd_addr <= '0;
                end
            endcase
        end
    end

    assign rd_addr = r_rd_addr;

    sat_ctr #(.W(16)) u_ok (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_inc_ok),
        .o_q   (cnt_ok)
    );

    sat_ctr #(.W(16)) u_drop (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_inc_drop),
        .o_q   (cnt_drop)
    );

    sat_ctr #(.W(16)) u_ovr (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_inc_ovr),
        .o_q   (cnt_overrun)
    );

endmodule

// File: doc/mac_rx_ctrl.md
MAC_RX_CTRL -- requirements
Module: mac_rx_ctrl

Interface
REQ-001 Parameter: MY_MAC, 48'h02_00_00_00_00_01, station address accepted as destination.
REQ-002 Parameter: ETHERTYPE, 16'h88B5, only EtherType forwarded.
REQ-003 Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- doorbell  in  1  one-cycle pulse: pktbuf holds a CRC-good frame.
- pktbuf_maxaddr  in  11  address of last valid frame byte, CRC already stripped.
- rd_addr  out  11  byte address into pktbuf.
- rd_data  in  8  pktbuf[rd_addr], combinational, zero-latency.
- out_data  out  8  payload byte.
- out_valid  out  1  payload byte valid.
- out_ready  in  1  downstream accepts byte.
- out_last  out  1  final payload byte of frame.
- busy  out  1  controller not in IDLE.
- cnt_ok  out  16  frames fully forwarded.
- cnt_drop  out  16  frames rejected by filter or runt check.
- cnt_overrun  out  16  doorbells ignored while busy.

Function
REQ-004 States SHALL be IDLE, HDR, STREAM.
REQ-005 IDLE: on doorbell, latch pktbuf_maxaddr into maxaddr_q, set rd_addr=0, go to HDR next cycle.
REQ-006 IDLE, doorbell with pktbuf_maxaddr < 14 (no payload byte): stay IDLE, cnt_drop +1.
REQ-007 HDR: one byte per cycle, rd_addr 0..13; bytes 0-5 compared MSB-first to MY_MAC or 48'hFFFF_FFFF_FFFF, bytes 12-13 compared big-endian to ETHERTYPE.
REQ-008 HDR, after address 13: all matched -> STREAM with rd_addr=14; otherwise -> IDLE, cnt_drop +1; HDR duration is exactly 14 cycles.
REQ-009 A mismatch SHALL NOT abort HDR early; the decision is taken only after byte 13.
REQ-010 STREAM: out_valid=1, out_data=rd_data, out_last=(rd_addr==maxaddr_q).
REQ-011 STREAM: on out_valid&out_ready, rd_addr +1; out_data/out_last SHALL hold stable while out_ready=0.
REQ-012 STREAM: transfer with out_last=1 -> IDLE next cycle, cnt_ok +1, out_valid=0 in that IDLE cycle.
REQ-013 Payload length forwarded SHALL equal maxaddr_q-13 bytes.
REQ-014 doorbell in HDR or STREAM: ignored, cnt_overrun +1, current frame continues unchanged (maxaddr_q not reloaded).
REQ-015 doorbell in the same cycle as the STREAM->IDLE transition: counts as overrun, not accepted.
REQ-016 All counters SHALL saturate at 16'hFFFF.
REQ-017 rd_addr SHALL be 0 in IDLE; busy=1 exactly in HDR and STREAM.
REQ-018 out_valid SHALL be 0 outside STREAM.

Reset
REQ-019 rst SHALL force IDLE next edge: rd_addr=0, out_valid=0, out_last=0, out_data=0, busy=0, all counters 0, maxaddr_q=0, match flags cleared.
REQ-020 rst mid-HDR or mid-STREAM SHALL abandon the frame without incrementing any counter; no further out_valid.
REQ-021 doorbell coincident with rst SHALL be ignored.

Structure
REQ-022 Shared package mac_pkg SHALL hold: state enum (IDLE/HDR/STREAM), ETH_HDR_LEN=14, BCAST_MAC, PKTBUF_AW=11, default MY_MAC and ETHERTYPE.
REQ-023 One sub-module: sat_ctr (16-bit saturating incrementer, synchronous reset), instantiated three times.

Verification
REQ-024 Unicast to MY_MAC, EtherType 88B5, maxaddr=63, out_ready=1 -> 50 payload bytes equal pktbuf[14..63], out_last on byte 50, cnt_ok=1.
REQ-025 Broadcast frame, maxaddr=14, out_ready toggling 1-0-1 -> single byte pktbuf[14] with out_last=1, held stable during stall, cnt_ok=1.
REQ-026 Destination 02:00:00:00:00:02 -> no out_valid, IDLE after 14 HDR cycles, cnt_drop=1; EtherType 0800 -> same.
REQ-027 doorbell with maxaddr=13 -> stays IDLE, cnt_drop=1; second doorbell during STREAM -> cnt_overrun=1, first frame completes intact.
REQ-028 rst asserted mid-STREAM at byte 5 -> out_valid=0 next cycle, all counters 0, next valid frame forwarded normally.
REQ-029 Force cnt_drop to 16'hFFFF via 65535 rejected frames (or preload in sim) then one more reject -> stays 16'hFFFF.
